usbh_root_port_mux: RTL
=======================

Name: usbh_root_port_mux

Overview:
- N-port root-hub front end between the single UTMI-side host controller and N usb_fs_phy instances.
- Per port: connect/disconnect debounce, full/low-speed detection, bus-reset generation and enable/status tracking.
- Routes the controller UTMI interface to one selected port; port switches occur only when the bus is idle.
- Generalises the single-port controller/PHY pairing to a parametrised multi-port hub with its own port state.

Parameters:
NUM_PORTS, 4, number of downstream ports (1..16)
PORT_W, $clog2(NUM_PORTS) min 1, width of port index
DEBOUNCE_CYCLES, 4800000, cycles of stable non-SE0 before connect (100 ms at 48 MHz)
RESET_CYCLES, 480000, cycles of bus reset asserted (10 ms)
DISCONNECT_CYCLES, 120, cycles of stable SE0 before disconnect (2.5 us)

Ports:
clk_i  in  1  system clock, 48 MHz
n_rst_i  in  1  asynchronous active-low reset
ctrl_data_out_i  in  8  controller TX byte
ctrl_txvalid_i  in  1  controller TX valid
ctrl_op_mode_i  in  2  controller op mode
ctrl_xcvrselect_i  in  2  controller transceiver select
ctrl_termselect_i  in  1  controller termination select
ctrl_data_in_o  out  8  RX byte from selected port
ctrl_txready_o  out  1  txready from selected port
ctrl_rxvalid_o  out  1  rxvalid from selected port
ctrl_rxactive_o  out  1  rxactive from selected port
ctrl_rxerror_o  out  1  rxerror from selected port
ctrl_linestate_o  out  2  linestate of selected port
port_sel_req_i  in  1  request to change selected port
port_sel_i  in  PORT_W  requested port index
port_sel_ack_o  out  1  one-cycle pulse: selection applied
port_sel_err_o  out  1  one-cycle pulse: index >= NUM_PORTS
port_cur_o  out  PORT_W  currently selected port
port_reset_i  in  NUM_PORTS  per-port bus-reset start pulse
port_change_clr_i  in  NUM_PORTS  clear per-port change bit
port_connected_o  out  NUM_PORTS  device present
port_lowspeed_o  out  NUM_PORTS  device is low speed
port_enabled_o  out  NUM_PORTS  port enabled
port_resetting_o  out  NUM_PORTS  bus reset in progress
port_change_o  out  NUM_PORTS  sticky status-change bit
phy_data_out_o  out  NUM_PORTS*8  per-PHY TX byte
phy_txvalid_o  out  NUM_PORTS  per-PHY TX valid
phy_op_mode_o  out  NUM_PORTS*2  per-PHY op mode
phy_xcvrselect_o  out  NUM_PORTS*2  per-PHY xcvrselect
phy_termselect_o  out  NUM_PORTS  per-PHY termselect
phy_reset_assert_o  out  NUM_PORTS  drives PHY usb_reset_assert_i
phy_data_in_i  in  NUM_PORTS*8  per-PHY RX byte
phy_txready_i / phy_rxvalid_i / phy_rxactive_i / phy_rxerror_i  in  NUM_PORTS each  per-PHY UTMI status
phy_linestate_i  in  NUM_PORTS*2  per-PHY linestate

Behaviour:
- Reset: selection = 0; all ports DISCONNECTED; all status outputs, ack, err and phy_reset_assert_o = 0.
- Routing is combinational, zero latency. Selected port receives ctrl_* drive signals; ctrl_* outputs mirror the selected port.
- Non-selected ports: data 0, txvalid 0, op_mode 2'b01 (non-driving), xcvrselect/termselect 0.
- Selection: port_sel_req_i sampled each cycle.
  - Index >= NUM_PORTS: err pulse next cycle, selection unchanged.
  - Otherwise applied on the first cycle with ctrl_txvalid_i=0 and selected rxactive=0, with ack pulsing that same cycle.
  - Request is held internally until applied; a new request overwrites a pending one.
- Per-port FSM states: DISCONNECTED, DEBOUNCE, CONNECTED, RESETTING, ENABLED.
  - DISCONNECTED -> DEBOUNCE when linestate != SE0.
  - DEBOUNCE: counter increments while linestate is stable and non-SE0; any change restarts the count; SE0 -> DISCONNECTED.
  - At DEBOUNCE_CYCLES -> CONNECTED: lowspeed latched = (linestate == 2'b10); change set.
  - CONNECTED/ENABLED + port_reset_i -> RESETTING: phy_reset_assert_o=1 for exactly RESET_CYCLES, then ENABLED with change set.
  - CONNECTED/ENABLED: SE0 stable for DISCONNECT_CYCLES -> DISCONNECTED, change set, lowspeed cleared.
- port_reset_i is ignored in DISCONNECTED, DEBOUNCE and RESETTING.
- SE0 during RESETTING is not treated as a disconnect. Disconnect counting starts fresh on entry to ENABLED.
- Change bit: set and clear in the same cycle -> set wins.
- Disconnect of the selected port mid-transfer: routing unchanged; the controller sees the PHY signals as-is.
- Counters saturate and are sized from the largest cycle parameter.

Decomposition:
- Package usbh_pkg holds:
  - port_state_t enum
  - OPMODE_NORMAL=2'b00, OPMODE_NONDRIVING=2'b01, OPMODE_NOSTUFF=2'b10
  - LS_SE0=2'b00, LS_J=2'b01, LS_K=2'b10
- Sub-module usbh_port_fsm (one port: debounce, reset timer, status), instantiated per port via generate.
- The mux and selection logic stay in the top module.

Test Plan:
1. Reset, NUM_PORTS=4, DEBOUNCE_CYCLES=16: port 2 linestate=01 for 16 cycles -> port_connected_o=4'b0100, lowspeed=0, change[2]=1.
2. Connected port 1 (linestate=10), pulse port_reset_i[1] with RESET_CYCLES=32 -> phy_reset_assert_o[1] high exactly 32 cycles, then enabled[1]=1, lowspeed[1]=1, change[1]=1.
3. Request sel=3 while ctrl_txvalid_i=1 -> no ack. Drop txvalid -> ack the same cycle, port_cur_o=3, phy_txvalid_o[3] follows ctrl.
4. port_sel_i=5 with NUM_PORTS=4 -> port_sel_err_o pulse, port_cur_o unchanged, no ack.
5. Enabled port 0: SE0 for 119 cycles then J -> still enabled. SE0 for 120 cycles -> disconnected, change[0]=1.
6. Simultaneous change set and port_change_clr_i on the same port -> change stays 1. Assert n_rst_i mid-RESETTING -> all outputs 0 immediately.

Source files
------------

// File: rtl/usbh_pkg.sv
// Shared types and constants for the USB host root-port front end.
// Port state encoding, UTMI op modes and linestate values.
package usbh_pkg;

  typedef enum logic [2:0] {
    PS_DISCONNECTED = 3'd0,
    PS_DEBOUNCE     = 3'd1,
    PS_CONNECTED    = 3'd2,
    PS_RESETTING    = 3'd3,
    PS_ENABLED      = 3'd4
  } port_state_t;

  localparam logic [1:0] OPMODE_NORMAL     = 2'b00;
  localparam logic [1:0] OPMODE_NONDRIVING = 2'b01;
  localparam logic [1:0] OPMODE_NOSTUFF    = 2'b10;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usbh_port_fsm.sv
// One downstream port: connect debounce, speed latch, bus-reset timer,
// disconnect detection and sticky change bit.
module usbh_port_fsm
  import usbh_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4800000,
  parameter int RESET_CYCLES      = 480000,
  parameter int DISCONNECT_CYCLES = 120
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic [1:0] linestate_i,
  input  logic       reset_req_i,
  input  logic       change_clr_i,
  output logic       connected_o,
  output logic       lowspeed_o,
  output logic       enabled_o,
  output logic       resetting_o,
  output logic       change_o
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, RESET_CYCLES, DISCONNECT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_TH  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RST_TH  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] DISC_TH = CNT_W'(DISCONNECT_CYCLES);

  port_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       last_ls_q, last_ls_d;
  logic             lowspeed_q, lowspeed_d;
  logic             change_q, change_d;
  logic             change_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= PS_DISCONNECTED;
      cnt_q      <= '0;
      last_ls_q  <= LS_SE0;
      lowspeed_q <= 1'b0;
      change_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ls_q  <= last_ls_d;
      lowspeed_q <= lowspeed_d;
      change_q   <= change_d;
    end
  end

  // cnt_q is shared: debounce run length, reset time, or SE0 run length
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ls_d  = last_ls_q;
    lowspeed_d = lowspeed_q;
    change_set = 1'b0;
    cnt_inc    = sat_inc(cnt_q);
    unique case (state_q)
      PS_DISCONNECTED: begin
        if (linestate_i != LS_SE0) begin
          last_ls_d = linestate_i;
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d    = PS_CONNECTED;
            cnt_d      = '0;
            lowspeed_d = (linestate_i == LS_K);
            change_set = 1'b1;
          end else begin
            state_d = PS_DEBOUNCE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PS_DEBOUNCE: begin
        if (linestate_i == LS_SE0) begin
          state_d = PS_DISCONNECTED;
          cnt_d   = '0;
        end else if (linestate_i != last_ls_q) begin
          last_ls_d = linestate_i;
          cnt_d     = CNT_W'(1);
        end else if (cnt_inc >= DEB_TH) begin
          state_d    = PS_CONNECTED;
          cnt_d      = '0;
          lowspeed_d = (linestate_i == LS_K);
          change_set = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PS_CONNECTED, PS_ENABLED: begin
        if (reset_req_i) begin
          state_d = PS_RESETTING;
          cnt_d   = '0;
        end else if (linestate_i == LS_SE0) begin
          if (cnt_inc >= DISC_TH) begin
            state_d    = PS_DISCONNECTED;
            cnt_d      = '0;
            lowspeed_d = 1'b0;
            change_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      PS_RESETTING: begin
        if (cnt_inc >= RST_TH) begin
          state_d    = PS_ENABLED;
          cnt_d      = '0;
          change_set = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = PS_DISCONNECTED;
        cnt_d   = '0;
      end
    endcase
    change_d = change_set | (change_q & ~change_clr_i);
  end

  always_comb begin
    connected_o = (state_q == PS_CONNECTED) || (state_q == PS_RESETTING) ||
                  (state_q == PS_ENABLED);
    enabled_o   = (state_q == PS_ENABLED);
    resetting_o = (state_q == PS_RESETTING);
    lowspeed_o  = lowspeed_q;
    change_o    = change_q;
  end

endmodule

// File: rtl/usbh_root_port_mux.sv
// Multi-port root-hub front end: per-port status FSMs plus a zero-latency
// UTMI router that only switches the selected port while the bus is idle.
module usbh_root_port_mux
  import usbh_pkg::*;
#(
  parameter int NUM_PORTS         = 4,
  parameter int PORT_W            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int DEBOUNCE_CYCLES   = 4800000,
  parameter int RESET_CYCLES      = 480000,
  parameter int DISCONNECT_CYCLES = 120
) (
  input  logic                   clk_i,
  input  logic                   n_rst_i,
  input  logic [7:0]             ctrl_data_out_i,
  input  logic                   ctrl_txvalid_i,
  input  logic [1:0]             ctrl_op_mode_i,
  input  logic [1:0]             ctrl_xcvrselect_i,
  input  logic                   ctrl_termselect_i,
  output logic [7:0]             ctrl_data_in_o,
  output logic                   ctrl_txready_o,
  output logic                   ctrl_rxvalid_o,
  output logic                   ctrl_rxactive_o,
  output logic                   ctrl_rxerror_o,
  output logic [1:0]             ctrl_linestate_o,
  input  logic                   port_sel_req_i,
  input  logic [PORT_W-1:0]      port_sel_i,
  output logic                   port_sel_ack_o,
  output logic                   port_sel_err_o,
  output logic [PORT_W-1:0]      port_cur_o,
  input  logic [NUM_PORTS-1:0]   port_reset_i,
  input  logic [NUM_PORTS-1:0]   port_change_clr_i,
  output logic [NUM_PORTS-1:0]   port_connected_o,
  output logic [NUM_PORTS-1:0]   port_lowspeed_o,
  output logic [NUM_PORTS-1:0]   port_enabled_o,
  output logic [NUM_PORTS-1:0]   port_resetting_o,
  output logic [NUM_PORTS-1:0]   port_change_o,
  output logic [NUM_PORTS*8-1:0] phy_data_out_o,
  output logic [NUM_PORTS-1:0]   phy_txvalid_o,
  output logic [NUM_PORTS*2-1:0] phy_op_mode_o,
  output logic [NUM_PORTS*2-1:0] phy_xcvrselect_o,
  output logic [NUM_PORTS-1:0]   phy_termselect_o,
  output logic [NUM_PORTS-1:0]   phy_reset_assert_o,
  input  logic [NUM_PORTS*8-1:0] phy_data_in_i,
  input  logic [NUM_PORTS-1:0]   phy_txready_i,
  input  logic [NUM_PORTS-1:0]   phy_rxvalid_i,
  input  logic [NUM_PORTS-1:0]   phy_rxactive_i,
  input  logic [NUM_PORTS-1:0]   phy_rxerror_i,
  input  logic [NUM_PORTS*2-1:0] phy_linestate_i
);

  localparam logic [PORT_W:0] NP_LIM = (PORT_W + 1)'(NUM_PORTS);

  logic [PORT_W-1:0]    cur_q, cur_d;
  logic [PORT_W-1:0]    pend_idx_q, pend_idx_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;
  logic                 req_ok, bus_idle, apply;
  logic [NUM_PORTS-1:0] resetting;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    usbh_port_fsm #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .RESET_CYCLES     (RESET_CYCLES),
      .DISCONNECT_CYCLES(DISCONNECT_CYCLES)
    ) u_port (
      .clk_i       (clk_i),
      .n_rst_i     (n_rst_i),
      .linestate_i (phy_linestate_i[g*2 +: 2]),
      .reset_req_i (port_reset_i[g]),
      .change_clr_i(port_change_clr_i[g]),
      .connected_o (port_connected_o[g]),
      .lowspeed_o  (port_lowspeed_o[g]),
      .enabled_o   (port_enabled_o[g]),
      .resetting_o (resetting[g]),
      .change_o    (port_change_o[g])
    );
  end

  assign port_resetting_o   = resetting;
  assign phy_reset_assert_o = resetting;

  // A request is taken immediately when the bus is idle; otherwise it waits,
  // and a newer valid request replaces the waiting one.
  always_comb begin
    req_ok     = port_sel_req_i && ({1'b0, port_sel_i} < NP_LIM);
    err_d      = port_sel_req_i && ({1'b0, port_sel_i} >= NP_LIM);
    bus_idle   = !ctrl_txvalid_i && !ctrl_rxactive_o;
    apply      = bus_idle && (req_ok || pend_q);
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    if (apply) begin
      cur_d  = req_ok ? port_sel_i : pend_idx_q;
      pend_d = 1'b0;
    end else if (req_ok) begin
      pend_d     = 1'b1;
      pend_idx_d = port_sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cur_q      <= '0;
      pend_idx_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      pend_idx_q <= pend_idx_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign port_sel_ack_o = apply;
  assign port_sel_err_o = err_q;
  assign port_cur_o     = cur_q;

  always_comb begin
    ctrl_data_in_o   = '0;
    ctrl_txready_o   = 1'b0;
    ctrl_rxvalid_o   = 1'b0;
    ctrl_rxactive_o  = 1'b0;
    ctrl_rxerror_o   = 1'b0;
    ctrl_linestate_o = LS_SE0;
    phy_data_out_o   = '0;
    phy_txvalid_o    = '0;
    phy_op_mode_o    = '0;
    phy_xcvrselect_o = '0;
    phy_termselect_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cur_q == PORT_W'(p)) begin
        ctrl_data_in_o         = phy_data_in_i[p*8 +: 8];
        ctrl_txready_o         = phy_txready_i[p];
        ctrl_rxvalid_o         = phy_rxvalid_i[p];
        ctrl_rxactive_o        = phy_rxactive_i[p];
        ctrl_rxerror_o         = phy_rxerror_i[p];
        ctrl_linestate_o       = phy_linestate_i[p*2 +: 2];
        phy_data_out_o[p*8 +: 8]   = ctrl_data_out_i;
        phy_txvalid_o[p]           = ctrl_txvalid_i;
        phy_op_mode_o[p*2 +: 2]    = ctrl_op_mode_i;
        phy_xcvrselect_o[p*2 +: 2] = ctrl_xcvrselect_i;
        phy_termselect_o[p]        = ctrl_termselect_i;
      end else begin
        phy_op_mode_o[p*2 +: 2] = OPMODE_NONDRIVING;
      end
    end
  end

endmodule
